transfer_sequencer: RTL and testbench

TRANSFER_SEQUENCER -- requirements
Module: transfer_sequencer

---
 rtl/transfer_sequencer.sv | 172 +++++++++++++++++
 tb/tb_transfer_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/transfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : transfer_sequencer
// Brief    : Sequences one receive-then-drain transfer: flush FIFO, collect
//            bytes from the receiver, deliver them to the output, and finish
//            in DONE or ERROR with a latched cause code.
// Revision : 1.0 - initial release
// ============================================================================
module transfer_sequencer #(
  parameter logic [11:0] TIMEOUT_CYCLES = 12'd4000,
  parameter int          CNT_W          = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             fifo_we,
  input  logic             com_finish,
  input  logic [3:0]       com_error,
  input  logic [7:0]       crc_in,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  input  logic             out_done,
  output logic             com_enable,
  output logic             out_enable,
  output logic             fifo_flush,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_code,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] tx_count,
  output logic [3:0]       err_code,
  output logic [7:0]       crc_latched
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    RECV  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [3:0]       ERR_FULL    = 4'hE;
  localparam logic [3:0]       ERR_UNDER   = 4'hD;
  localparam logic [3:0]       ERR_TIMEOUT = 4'hF;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rx_q, rx_d, tx_q, tx_d;
  logic [CNT_W-1:0] rx_inc, tx_inc;
  logic [11:0]      wd_q, wd_d;
  logic [3:0]       err_q, err_d;
  logic [7:0]       crc_q, crc_d;
  logic             wd_expired;
  logic             com_enable_q, out_enable_q, fifo_flush_q, busy_q, done_q;

  // Next-state and datapath decisions for the whole sequencer
  always_comb begin
    state_d    = state_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    wd_d       = wd_q;
    err_d      = err_q;
    crc_d      = crc_q;
    rx_inc     = (rx_q == CNT_MAX) ? rx_q : rx_q + 1'b1;
    tx_inc     = (tx_q == CNT_MAX) ? tx_q : tx_q + 1'b1;
    wd_expired = (wd_q == TIMEOUT_CYCLES - 12'd1);

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = FLUSH;
          rx_d    = '0;
          tx_d    = '0;
          err_d   = 4'h0;
        end
      end
      FLUSH: state_d = RECV;
      RECV: begin
        // A write into a full FIFO loses data, so it outranks frame completion
        if (fifo_we && fifo_full) begin
          state_d = ERROR;
          err_d   = ERR_FULL;
        end else begin
          if (fifo_we) rx_d = rx_inc;
          if (com_finish) begin
            if (com_error != 4'h0) begin
              state_d = ERROR;
              err_d   = com_error;
            end else begin
              state_d = DRAIN;
              crc_d   = crc_in;
            end
          end else if (fifo_we) begin
            wd_d = '0;
          end else if (wd_expired) begin
            state_d = ERROR;
            err_d   = ERR_TIMEOUT;
          end else begin
            wd_d = wd_q + 12'd1;
          end
        end
      end
      DRAIN: begin
        // An acknowledge beyond the received count means the output over-read
        if (out_done && (tx_q == rx_q)) begin
          state_d = ERROR;
          err_d   = ERR_UNDER;
        end else begin
          if (out_done) tx_d = tx_inc;
          if ((tx_d == rx_q) && fifo_empty) begin
            state_d = DONE;
          end else if (out_done) begin
            wd_d = '0;
          end else if (wd_expired) begin
            state_d = ERROR;
            err_d   = ERR_TIMEOUT;
          end else begin
            wd_d = wd_q + 12'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Every state change restarts the watchdog
    if (state_d != state_q) wd_d = '0;
  end

  // State, counters and registered outputs (outputs decoded from next state)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rx_q         <= '0;
      tx_q         <= '0;
      wd_q         <= '0;
      err_q        <= 4'h0;
      crc_q        <= 8'h00;
      com_enable_q <= 1'b0;
      out_enable_q <= 1'b0;
      fifo_flush_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
      crc_q        <= crc_d;
      com_enable_q <= (state_d == RECV);
      out_enable_q <= (state_d == DRAIN);
      fifo_flush_q <= (state_d == FLUSH);
      busy_q       <= (state_d == FLUSH) || (state_d == RECV) || (state_d == DRAIN);
      done_q       <= (state_d == DONE);
    end
  end

  assign com_enable  = com_enable_q;
  assign out_enable  = out_enable_q;
  assign fifo_flush  = fifo_flush_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign state_code  = state_q;
  assign rx_count    = rx_q;
  assign tx_count    = tx_q;
  assign err_code    = err_q;
  assign crc_latched = crc_q;

endmodule
`default_nettype wire

// File: tb/tb_transfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_transfer_sequencer
// Brief    : Directed self-checking bench for transfer_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_transfer_sequencer;

  localparam int CNT_W = 10;
  localparam int TO    = 4000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             fifo_we = 1'b0;
  logic             com_finish = 1'b0;
  logic [3:0]       com_error = 4'h0;
  logic [7:0]       crc_in = 8'h00;
  logic             fifo_empty = 1'b0;
  logic             fifo_full = 1'b0;
  logic             out_done = 1'b0;
  logic             com_enable, out_enable, fifo_flush, busy, done;
  logic [2:0]       state_code;
  logic [CNT_W-1:0] rx_count, tx_count;
  logic [3:0]       err_code;
  logic [7:0]       crc_latched;

  int   checks = 0;
  int   errors = 0;
  logic oe_seen = 1'b0;
  int   flush_pulses = 0;

  transfer_sequencer #(
    .TIMEOUT_CYCLES(12'(TO)),
    .CNT_W         (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .fifo_we    (fifo_we),
    .com_finish (com_finish),
    .com_error  (com_error),
    .crc_in     (crc_in),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .out_done   (out_done),
    .com_enable (com_enable),
    .out_enable (out_enable),
    .fifo_flush (fifo_flush),
    .busy       (busy),
    .done       (done),
    .state_code (state_code),
    .rx_count   (rx_count),
    .tx_count   (tx_count),
    .err_code   (err_code),
    .crc_latched(crc_latched)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle; also tracks sticky output observations
  task automatic tick();
    @(posedge clk);
    #1;
    if (out_enable) oe_seen = 1'b1;
    if (fifo_flush) flush_pulses++;
  endtask

  task automatic go_recv();
    start = 1'b1; tick(); start = 1'b0;   // FLUSH
    tick();                                // RECV
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    check("reset_state", state_code, 0);
    check("reset_busy_done", {busy, done, com_enable, out_enable, fifo_flush}, 0);
    check("reset_counts", {rx_count, tx_count, err_code, crc_latched}, 0);

    // Normal transfer of three bytes
    start = 1'b1; tick(); start = 1'b0;
    check("flush_state", state_code, 1);
    check("flush_pulse", {fifo_flush, busy, com_enable}, 3'b110);
    tick();
    check("recv_state", state_code, 2);
    check("recv_enables", {fifo_flush, com_enable, out_enable}, 3'b010);
    fifo_we = 1'b1; tick(); tick(); tick(); fifo_we = 1'b0;
    check("recv_rx3", rx_count, 3);
    com_finish = 1'b1; crc_in = 8'hA5; tick(); com_finish = 1'b0;
    check("drain_state", state_code, 3);
    check("drain_enables", {com_enable, out_enable}, 2'b01);
    check("crc_a5", crc_latched, 8'hA5);
    out_done = 1'b1; tick(); tick();
    check("drain_tx2", tx_count, 2);
    check("drain_not_done", state_code, 3);
    fifo_empty = 1'b1; tick(); out_done = 1'b0;
    check("done_state", state_code, 4);
    check("done_flags", {done, busy, out_enable}, 3'b100);
    check("done_counts", {rx_count, tx_count}, {10'd3, 10'd3});
    out_done = 1'b1; fifo_we = 1'b1; tick(); out_done = 1'b0; fifo_we = 1'b0;
    check("idle_ignore_pulses", {rx_count, tx_count}, {10'd3, 10'd3});

    // Receiver error code
    oe_seen = 1'b0;
    go_recv();
    fifo_we = 1'b1; tick(); tick(); fifo_we = 1'b0;
    com_finish = 1'b1; com_error = 4'h3; tick(); com_finish = 1'b0; com_error = 4'h0;
    check("comerr_state", state_code, 5);
    check("comerr_code", err_code, 3);
    check("comerr_rx", rx_count, 2);
    check("comerr_no_oe", oe_seen, 0);
    start = 1'b1; tick(); start = 1'b0;
    check("restart_flush", state_code, 1);
    check("restart_clear", {err_code, rx_count, tx_count}, 0);

    // Full FIFO beats simultaneous com_finish
    tick();
    fifo_full = 1'b1; fifo_we = 1'b1; com_finish = 1'b1; crc_in = 8'h5A;
    tick();
    fifo_full = 1'b0; fifo_we = 1'b0; com_finish = 1'b0;
    check("full_state", state_code, 5);
    check("full_code", err_code, 4'hE);
    check("full_crc_kept", crc_latched, 8'hA5);

    // Zero-length frame
    go_recv();
    fifo_empty = 1'b1; com_finish = 1'b1; crc_in = 8'h3C; tick(); com_finish = 1'b0;
    check("zero_drain", state_code, 3);
    tick();
    check("zero_done", state_code, 4);
    check("zero_crc", crc_latched, 8'h3C);

    // Underflow: acknowledge beyond received count
    fifo_empty = 1'b0;
    go_recv();
    fifo_we = 1'b1; tick(); fifo_we = 1'b0;
    com_finish = 1'b1; tick(); com_finish = 1'b0;
    out_done = 1'b1; tick();
    check("under_tx1", tx_count, 1);
    check("under_still_drain", state_code, 3);
    tick(); out_done = 1'b0;
    check("under_state", state_code, 5);
    check("under_code", err_code, 4'hD);
    check("under_tx_held", tx_count, 1);

    // Watchdog in DRAIN
    go_recv();
    fifo_we = 1'b1; tick(); tick(); fifo_we = 1'b0;
    com_finish = 1'b1; tick(); com_finish = 1'b0;
    out_done = 1'b1; tick(); out_done = 1'b0;
    repeat (TO - 1) tick();
    check("wd_edge_drain", state_code, 3);
    tick();
    check("wd_state", state_code, 5);
    check("wd_code", err_code, 4'hF);
    check("wd_tx", tx_count, 1);

    // Start ignored in RECV, reset mid-DRAIN
    go_recv();
    flush_pulses = 0;
    start = 1'b1; tick(); start = 1'b0;
    check("start_ign_state", state_code, 2);
    check("start_ign_flush", flush_pulses, 0);
    fifo_we = 1'b1; tick(); fifo_we = 1'b0;
    com_finish = 1'b1; crc_in = 8'h77; tick(); com_finish = 1'b0;
    out_done = 1'b1; tick(); out_done = 1'b0;
    check("pre_reset_tx", tx_count, 1);
    reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
    check("rst_state", state_code, 0);
    check("rst_flags", {busy, done, com_enable, out_enable, fifo_flush}, 0);
    check("rst_counts", {rx_count, tx_count, err_code, crc_latched}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
